dmem_wbuf: RTL and testbench
============================

// Module: dmem_wbuf
// PURPOSE
//  Data-memory responder for the single-cycle core's load/store port. Serves loads
//  combinationally; posts stores into a DEPTH-entry write buffer that drains into a
//  single-port word RAM on idle cycles. Sits between the core's
//  ALUResult/WriteData/ReadData port and the data RAM. Busy tells the controller to
//  hold PC and suppress register writeback.
// PARAMETERS
//  ADDR_W  6   word-address width; RAM holds 2**ADDR_W 32-bit words
//  DEPTH   4   write-buffer entries (power of 2, >=2)
// PORTS
//  clk       in   1   clock
//  reset     in   1   asynchronous, active-high reset
//  MemWrite  in   1   store request this cycle
//  MemRead   in   1   load request this cycle
//  A         in   32  byte address (ALUResult); word index = A[ADDR_W+1:2]
//  WD        in   32  store data (WriteData)
//  RD        out  32  load data (ReadData); combinational
//  Busy      out  1   request not completed this cycle; core must repeat it
//  Empty     out  1   write buffer holds no pending stores
// BEHAVIOUR
//  - Reset: head/tail/count=0, all entries invalid, Empty=1, Busy=0. RAM is not
//    cleared. Reset mid-operation discards pending stores; RAM keeps prior contents.
//  - A[1:0] and A[31:ADDR_W+2] are ignored; addresses alias modulo 2**(ADDR_W+2).
//  - MemWrite=1 and MemRead=1 together is treated as a store; MemRead is ignored.
//  - Store, count<DEPTH: Busy=0; {word addr, WD} enqueued at tail on the rising edge.
//  - Store, count==DEPTH: Busy=1, no enqueue; head drained this cycle.
//    The retried store is accepted next cycle.
//  - Load: RD = data of the youngest buffer entry with matching word address.
//    If no entry matches, RD = RAM[addr]. Busy=0. Zero latency (same cycle).
//  - Drain: one entry per cycle, head to RAM, then pop. Drain happens when count>0 and
//    there is no request, or in the full-store stall case. No other drains.
//  - Enqueue and drain never coincide, so count changes by at most 1 per cycle.
//  - Entries drain in FIFO order, so same-address stores reach RAM in program order.
//  - No request: RD = RAM[addr] (don't-care to the core).
//  - Busy and RD are combinational from inputs and state. Empty = (count==0),
//    registered-state only.
// CONFIGURATION
//  DMEM_FWD_EN defined: load forwarding from the buffer, as above.
//  DMEM_FWD_EN undefined: a load whose address matches any entry asserts Busy=1.
//  - That cycle forces a head drain; repeats until no entry matches.
//  - Then RD = RAM[addr]. The matching logic is kept; only its use changes.
// STRUCTURE
//  dmem_pkg holds:
//  - typedef struct packed {logic [ADDR_W-1:0] addr; logic [31:0] data;} wb_entry_t
//  - localparam defaults for ADDR_W and DEPTH
//  - pointer/count width helper: $clog2(DEPTH)+1 bits for count
//  Sub-module wbuf_fifo holds the entry array, head/tail/count, per-entry valid,
//  push/pop, and a youngest-match search (hit, hit_data).
//  dmem_wbuf holds the RAM array, the drain/Busy decision and the RD mux.
// TESTING
//  1 reset; store A=0x10 WD=0xDEADBEEF; next cycle load 0x10 -> RD=0xDEADBEEF, Busy=0.
//    Then idle 1 cycle -> Empty=1, RAM[4]=0xDEADBEEF.
//  2 stores to 0x0,0x4,0x8,0xC back-to-back, then store 0x14 -> Busy=1 that cycle.
//    Retry next cycle -> Busy=0. After 5 idle cycles RAM[0..3],RAM[5] hold the values.
//  3 store 0x20=1, store 0x20=2, load 0x20 -> RD=2. After draining, RAM[8]=2, not 1.
//  4 DMEM_FWD_EN undefined: store 0x30=0x55, load 0x30 -> Busy=1 one cycle.
//    Retry -> Busy=0, RD=0x55.
//  5 three pending stores, assert reset mid-cycle (async) -> Empty=1 at once.
//    Busy=0; RAM words untouched.
//  6 ADDR_W=6: store A=0x104 WD=7 and drain -> load A=0x4 returns RD=7 (alias).

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory write-buffer block.
package dmem_pkg;

  localparam int DMEM_ADDR_W = 6;  // word-address width, RAM = 2**ADDR_W words
  localparam int DMEM_DEPTH  = 4;  // write-buffer entries (power of 2, >= 2)

  // One posted store: word address plus the 32-bit data.
  typedef struct packed {
    logic [DMEM_ADDR_W-1:0] addr;
    logic [31:0]            data;
  } wb_entry_t;

  // Count must reach DEPTH itself, so it needs one bit more than a pointer.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/dmem_wbuf_fifo.sv
// Write-buffer FIFO: entry storage, head/tail/count, per-entry valid,
// push/pop, and a youngest-first address match for load forwarding.
module wbuf_fifo
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DEPTH  = DMEM_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [31:0]       push_data,
  input  logic              pop,
  input  logic [ADDR_W-1:0] search_addr,
  output logic [ADDR_W-1:0] head_addr,
  output logic [31:0]       head_data,
  output logic              hit,
  output logic [31:0]       hit_data,
  output logic              empty,
  output logic              full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  // Same layout as wb_entry_t, but sized by this instance's ADDR_W.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } ent_t;

  ent_t [DEPTH-1:0] ent_q, ent_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] sidx;

  // Next-state: push at tail or pop at head (the owner never asks for both).
  always_comb begin
    ent_d  = ent_q;
    vld_d  = vld_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (push) begin
      ent_d[tail_q] = '{addr: push_addr, data: push_data};
      vld_d[tail_q] = 1'b1;
      tail_d        = tail_q + PTR_W'(1);
      cnt_d         = cnt_q + CNT_W'(1);
    end else if (pop) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + PTR_W'(1);
      cnt_d         = cnt_q - CNT_W'(1);
    end
  end

  // Control state; reset discards every pending store.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Entry payload needs no reset: valid bits gate every use of it.
  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

  // Walk oldest to youngest from head so the last match wins (youngest store).
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    sidx     = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      sidx = head_q + PTR_W'(i);
      if (vld_q[sidx] && ent_q[sidx].addr == search_addr) begin
        hit      = 1'b1;
        hit_data = ent_q[sidx].data;
      end
    end
  end

  assign head_addr = ent_q[head_q].addr;
  assign head_data = ent_q[head_q].data;
  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == CNT_W'(DEPTH));

endmodule

// File: rtl/dmem_wbuf.sv
// Data-memory responder: combinational loads, stores posted to a write
// buffer that drains into the word RAM on idle cycles.
// Optional feature macro: DMEM_FWD_EN (load forwarding from the buffer).
// Without it, a load that matches a pending store stalls and drains until clear.
module dmem_wbuf
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DEPTH  = DMEM_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        Busy,
  output logic        Empty
);

  logic [31:0]       ram_q [2**ADDR_W];
  logic [ADDR_W-1:0] waddr;
  logic              store, load, idle;
  logic              push, drain, st_stall, ld_stall;
  logic [ADDR_W-1:0] head_addr;
  logic [31:0]       head_data, hit_data;
  logic              hit, empty, full;

  // Byte offset and high bits are ignored: addresses alias modulo the RAM size.
  assign waddr = A[ADDR_W+1:2];
  logic unused_a;
  assign unused_a = ^{A[31:ADDR_W+2], A[1:0]};

  wbuf_fifo #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .push_addr   (waddr),
    .push_data   (WD),
    .pop         (drain),
    .search_addr (waddr),
    .head_addr   (head_addr),
    .head_data   (head_data),
    .hit         (hit),
    .hit_data    (hit_data),
    .empty       (empty),
    .full        (full)
  );

  // Request decode, Busy and drain decision; a store wins over a simultaneous load.
  always_comb begin
    store    = MemWrite;
    load     = MemRead & ~MemWrite;
    idle     = ~MemWrite & ~MemRead;
    st_stall = store & full;
    push     = store & ~full;
`ifdef DMEM_FWD_EN
    ld_stall = 1'b0;
`else
    ld_stall = load & hit;
`endif
    Busy  = st_stall | ld_stall;
    // Enqueue and drain are mutually exclusive by construction.
    drain = (idle & ~empty) | st_stall | ld_stall;
  end

  // Load data: youngest buffered store when forwarding, else the RAM word.
  always_comb begin
    RD = ram_q[waddr];
`ifdef DMEM_FWD_EN
    if (load && hit) RD = hit_data;
`endif
  end

`ifndef DMEM_FWD_EN
  logic unused_fwd;
  assign unused_fwd = ^hit_data;
`endif

  // RAM is never cleared; only the buffer head ever writes it.
  always_ff @(posedge clk) begin
    if (drain) ram_q[head_addr] <= head_data;
  end

  assign Empty = empty;

endmodule

// File: tb/tb_dmem_wbuf.sv
// Bench for dmem_wbuf: directed vector table, an async-reset sequence, then
// random traffic against a queue-based reference model.
module tb_dmem_wbuf;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        reset, MemWrite, MemRead, Busy, Empty;
  logic [31:0] A, WD, RD;
  int          checks = 0, failures = 0;

  dmem_wbuf #(.ADDR_W(6), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .MemRead(MemRead),
    .A(A), .WD(WD), .RD(RD), .Busy(Busy), .Empty(Empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we, re;
    logic [31:0] a, wd;
    logic        chk_rd;
    logic [31:0] rd;
    logic        busy, empty;
  } vec_t;
  vec_t tbl[$];

  localparam logic [31:0] V0 = 32'h1111_0000, V1 = 32'h1111_0004, V2 = 32'h1111_0008;
  localparam logic [31:0] V3 = 32'h1111_000C, V5 = 32'h1111_0014;

  function automatic void addv(input logic we, input logic re, input logic [31:0] a,
                               input logic [31:0] wd, input logic chk_rd,
                               input logic [31:0] rd, input logic busy, input logic empty);
    vec_t v;
    v.we = we; v.re = re; v.a = a; v.wd = wd;
    v.chk_rd = chk_rd; v.rd = rd; v.busy = busy; v.empty = empty;
    tbl.push_back(v);
  endfunction
  function automatic void st(input logic [31:0] a, input logic [31:0] wd,
                             input logic busy, input logic empty);
    addv(1'b1, 1'b0, a, wd, 1'b0, 32'h0, busy, empty);
  endfunction
  function automatic void ld(input logic [31:0] a, input logic chk, input logic [31:0] rd,
                             input logic busy, input logic empty);
    addv(1'b0, 1'b1, a, 32'h0, chk, rd, busy, empty);
  endfunction
  function automatic void idl(input logic empty);
    addv(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, empty);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Called at posedge+1; leaves time at the following negedge for sampling.
  task automatic drive(input logic we, input logic re, input logic [31:0] a, input logic [31:0] wd);
    MemWrite = we; MemRead = re; A = a; WD = wd;
    #4;
  endtask
  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  // Reference model: FIFO of posted stores plus a word array for the RAM.
  wb_entry_t   mq[$];
  logic [31:0] mram[64];
  bit          mknown[64];

  task automatic mdrain();
    wb_entry_t e;
    e = mq.pop_front();
    mram[e.addr] = e.data;
    mknown[e.addr] = 1'b1;
  endtask

  task automatic model_step(input logic we, input logic re, input logic [31:0] a,
                            input logic [31:0] wd, output logic eb, output logic rdv,
                            output logic [31:0] erd);
    logic [5:0]  w;
    logic        found;
    logic [31:0] fd;
    wb_entry_t   e;
    w = a[7:2]; found = 1'b0; fd = '0;
    foreach (mq[i]) if (mq[i].addr == w) begin found = 1'b1; fd = mq[i].data; end
    eb = 1'b0; rdv = 1'b0; erd = mram[w];
    if (we) begin
      if (mq.size() == 4) begin eb = 1'b1; mdrain(); end
      else begin e.addr = w; e.data = wd; mq.push_back(e); end
    end else if (re) begin
`ifdef DMEM_FWD_EN
      rdv = found || mknown[w];
      erd = found ? fd : mram[w];
`else
      if (found) begin eb = 1'b1; mdrain(); end
      else rdv = mknown[w];
`endif
    end else if (mq.size() > 0) begin
      mdrain();
    end
  endtask

  task automatic rnd_cycle(input logic we, input logic re, input logic [31:0] a,
                           input logic [31:0] wd, output logic eb);
    logic        rdv, ee;
    logic [31:0] erd;
    drive(we, re, a, wd);
    ee = (mq.size() == 0);
    model_step(we, re, a, wd, eb, rdv, erd);
    chk("rnd_busy", 32'(Busy), 32'(eb));
    chk("rnd_empty", 32'(Empty), 32'(ee));
    if (rdv) chk("rnd_rd", RD, erd);
    next_cyc();
  endtask

  initial begin
    logic eb;
    reset = 1'b1; MemWrite = 1'b0; MemRead = 1'b0; A = '0; WD = '0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    chk("reset_empty", 32'(Empty), 32'd1);
    chk("reset_busy", 32'(Busy), 32'd0);
    next_cyc();

    // Store then load the same word; drain lands it in RAM.
    st(32'h10, 32'hDEADBEEF, 0, 1);
`ifdef DMEM_FWD_EN
    ld(32'h10, 1, 32'hDEADBEEF, 0, 0);
    idl(0);
`else
    ld(32'h10, 0, 32'h0, 1, 0);
`endif
    ld(32'h10, 1, 32'hDEADBEEF, 0, 1);
    // Fill the buffer, stall on the fifth store, retry, drain, read back.
    st(32'h00, V0, 0, 1); st(32'h04, V1, 0, 0); st(32'h08, V2, 0, 0); st(32'h0C, V3, 0, 0);
    st(32'h14, V5, 1, 0); st(32'h14, V5, 0, 0);
    idl(0); idl(0); idl(0); idl(0); idl(1);
    ld(32'h00, 1, V0, 0, 1); ld(32'h04, 1, V1, 0, 1); ld(32'h08, 1, V2, 0, 1);
    ld(32'h0C, 1, V3, 0, 1); ld(32'h14, 1, V5, 0, 1);
    // Two stores to one word: youngest wins, RAM ends with the later value.
    st(32'h20, 32'd1, 0, 1); st(32'h20, 32'd2, 0, 0);
`ifdef DMEM_FWD_EN
    ld(32'h20, 1, 32'd2, 0, 0); idl(0); idl(0);
`else
    ld(32'h20, 0, 32'h0, 1, 0); ld(32'h20, 0, 32'h0, 1, 0);
`endif
    ld(32'h20, 1, 32'd2, 0, 1);
    // Load hitting a pending store.
    st(32'h30, 32'h55, 0, 1);
`ifdef DMEM_FWD_EN
    ld(32'h30, 1, 32'h55, 0, 0); idl(0);
`else
    ld(32'h30, 0, 32'h0, 1, 0);
`endif
    ld(32'h30, 1, 32'h55, 0, 1);
    // Aliasing, with MemRead also high on the store (store wins).
    addv(1, 1, 32'h104, 32'd7, 0, 32'h0, 0, 1);
    idl(0);
    ld(32'h04, 1, 32'd7, 0, 1);
    ld(32'hFFFF_FF07, 1, 32'd7, 0, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].we, tbl[i].re, tbl[i].a, tbl[i].wd);
      chk($sformatf("vec%0d_busy", i), 32'(Busy), 32'(tbl[i].busy));
      chk($sformatf("vec%0d_empty", i), 32'(Empty), 32'(tbl[i].empty));
      if (tbl[i].chk_rd) chk($sformatf("vec%0d_rd", i), RD, tbl[i].rd);
      next_cyc();
    end

    // Async reset with three stores pending: buffer clears, RAM keeps old words.
    drive(1'b1, 1'b0, 32'h00, 32'hA0); next_cyc();
    drive(1'b1, 1'b0, 32'h08, 32'hA2); next_cyc();
    drive(1'b1, 1'b0, 32'h0C, 32'hA3);
    chk("rst_pre_empty", 32'(Empty), 32'd0);
    next_cyc();
    MemWrite = 1'b0; reset = 1'b1;
    #1;
    chk("rst_async_empty", 32'(Empty), 32'd1);
    MemWrite = 1'b1; A = 32'h0;
    #1;
    chk("rst_busy", 32'(Busy), 32'd0);
    MemWrite = 1'b0; reset = 1'b0;
    next_cyc();
    drive(1'b0, 1'b1, 32'h00, 32'h0); chk("rst_ram0", RD, V0); chk("rst_busy0", 32'(Busy), 32'd0); next_cyc();
    drive(1'b0, 1'b1, 32'h08, 32'h0); chk("rst_ram2", RD, V2); next_cyc();
    drive(1'b0, 1'b1, 32'h0C, 32'h0); chk("rst_ram3", RD, V3); next_cyc();

    // Random phase: fresh buffer, prefill every RAM word so the model knows it.
    reset = 1'b1; #1; reset = 1'b0;
    mq.delete();
    for (int w = 0; w < 64; w++) begin
      logic [31:0] wd;
      int          tries;
      wd = $urandom; tries = 0;
      do begin
        rnd_cycle(1'b1, 1'b0, {24'h0, 6'(w), 2'b00}, wd, eb);
        tries++;
      end while (eb && tries < 4);
    end
    for (int n = 0; n < 600; n++) begin
      logic        we, re;
      logic [5:0]  idx;
      logic [31:0] a;
      we  = ($urandom_range(0, 2) == 0);
      re  = ($urandom_range(0, 2) == 0);
      idx = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 7));
      a   = ($urandom & 32'hFFFF_FF00) | {24'h0, idx, 2'b00} | 32'($urandom_range(0, 3));
      rnd_cycle(we, re, a, $urandom, eb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
